// File: rtl/fetch_control.sv
// Fetch-stage sequencer: owns the PC, drives the instruction ROM address and feeds
// a 2-entry {pc, instr} queue toward decode; handles backend redirects and end-of-trace halt.
module fetch_control #(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned INSTR_WIDTH = 32,
    parameter int unsigned TRACE_BYTES = 48
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [ADDR_WIDTH-1:0]  rom_addr,
    input  logic [INSTR_WIDTH-1:0] rom_data,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ADDR_WIDTH-1:0]  out_pc,
    output logic [INSTR_WIDTH-1:0] out_instr,
    output logic                   halted
);

    typedef enum logic [0:0] {StFetch, StHalt} state_e;

    // One extra bit so a limit of exactly 2^ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0] TraceLimit = TRACE_BYTES[ADDR_WIDTH:0];

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic                   head_q, head_d;
    logic                   tail_q, tail_d;
    logic [1:0]             count_q, count_d;

    logic [ADDR_WIDTH-1:0]  q_pc_q    [2];
    logic [INSTR_WIDTH-1:0] q_instr_q [2];

    logic end_cond;
    logic pop;
    logic push;

    assign end_cond = (rom_data == '0) || ({1'b0, pc_q} >= TraceLimit);
    assign pop      = out_valid && out_ready;
    assign push     = (state_q == StFetch) && !redirect_valid && !end_cond &&
                      ((count_q < 2'd2) || pop);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (redirect_valid) begin
            // Flush wins over any same-cycle pop or push.
            state_d = StFetch;
            pc_d    = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
            head_d  = 1'b0;
            tail_d  = 1'b0;
            count_d = 2'd0;
        end else begin
            if ((state_q == StFetch) && end_cond) begin
                state_d = StHalt;
            end
            if (push) begin
                tail_d = tail_q + 1'b1;
                pc_d   = pc_q + ADDR_WIDTH'(4);
            end
            if (pop) begin
                head_d = head_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
            pc_q    <= '0;
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage needs no reset; outputs are masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            q_pc_q[tail_q]    <= pc_q;
            q_instr_q[tail_q] <= rom_data;
        end
    end

    assign rom_addr  = pc_q;
    assign out_valid = (count_q != 2'd0);
    assign out_pc    = out_valid ? q_pc_q[head_q] : '0;
    assign out_instr = out_valid ? q_instr_q[head_q] : '0;
    assign halted    = (state_q == StHalt);

endmodule

// File: tb/tb_fetch_control.sv
// Self-checking bench for fetch_control: per-cycle vector table plus a hand-written
// redirect-to-tail-of-trace sequence, against a behavioural ROM.
module tb_fetch_control;

    localparam int unsigned AW = 12;
    localparam int unsigned IW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] rom_addr;
    logic [IW-1:0] rom_data;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_pc;
    logic [IW-1:0] out_instr;
    logic          halted;
    logic          hole;

    int total = 0;
    int bad   = 0;

    fetch_control #(
        .ADDR_WIDTH (AW),
        .INSTR_WIDTH(IW),
        .TRACE_BYTES(48)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_instr     (out_instr),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] rom_word(input logic [AW-1:0] a, input logic h);
        if (h && a == 12'h010) return '0;
        return 32'hA500_0000 | {20'h0, a};
    endfunction

    always_comb rom_data = rom_word(rom_addr, hole);

    typedef struct {
        logic          rst;
        logic          rdy;
        logic          rv;
        logic [AW-1:0] rpc;
        logic          hl;
        logic          chk;
        logic          e_valid;
        logic [AW-1:0] e_pc;
        logic [AW-1:0] e_rom;
        logic          e_halt;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst, input logic rdy, input logic rv,
                                input logic [AW-1:0] rpc, input logic hl, input logic chk,
                                input logic ev, input logic [AW-1:0] epc,
                                input logic [AW-1:0] erom, input logic eh);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.hl = hl; v.chk = chk;
        v.e_valid = ev; v.e_pc = epc; v.e_rom = erom; v.e_halt = eh;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s vec=%0d got=%h want=%h", name, idx, got, exp);
        end
    endtask

    task automatic reset_cycle();
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int            n_seen;
        logic [AW-1:0] seen[$];
        logic          got_halt;

        reset = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; hole = 1'b0;

        // Straight-line 12-instruction trace at full throughput, then halt.
        reset_cycle();
        add(0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        for (int k = 1; k <= 12; k++) add(0, 1, 0, 0, 0, 1, 1, AW'(4 * (k - 1)), AW'(4 * k), 0);
        add(0, 1, 0, 0, 0, 1, 0, 0, 48, 1);
        add(0, 1, 0, 0, 0, 1, 0, 0, 48, 1);

        // Backpressure: queue fills with 0,4; PC parks at 8; release gives 0,4,8,12.
        reset_cycle();
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 1, 0, 4, 0);
        for (int k = 2; k <= 5; k++) add(0, 0, 0, 0, 0, 1, 1, 0, 8, 0);
        add(0, 1, 0, 0, 0, 1, 1, 0, 8, 0);
        add(0, 1, 0, 0, 0, 1, 1, 4, 12, 0);
        add(0, 1, 0, 0, 0, 1, 1, 8, 16, 0);
        add(0, 1, 0, 0, 0, 1, 1, 12, 20, 0);

        // Redirect to 0x01E in cycle 4 with a full queue.
        reset_cycle();
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 1, 0, 4, 0);
        add(0, 0, 0, 0, 0, 1, 1, 0, 8, 0);
        add(0, 0, 0, 0, 0, 1, 1, 0, 8, 0);
        add(0, 0, 1, 12'h01E, 0, 1, 1, 0, 8, 0);
        add(0, 1, 0, 0, 0, 1, 0, 0, 12'h01C, 0);
        add(0, 1, 0, 0, 0, 1, 1, 12'h01C, 12'h020, 0);
        add(0, 1, 0, 0, 0, 1, 1, 12'h020, 12'h024, 0);

        // Zero word at 0x010 halts; redirect to 0x004 resumes.
        reset_cycle();
        add(0, 1, 0, 0, 1, 1, 0, 0, 0, 0);
        for (int k = 1; k <= 4; k++) add(0, 1, 0, 0, 1, 1, 1, AW'(4 * (k - 1)), AW'(4 * k), 0);
        add(0, 1, 1, 12'h004, 1, 1, 0, 0, 12'h010, 1);
        add(0, 1, 0, 0, 1, 1, 0, 0, 12'h004, 0);
        add(0, 1, 0, 0, 1, 1, 1, 12'h004, 12'h008, 0);
        add(0, 1, 0, 0, 1, 1, 1, 12'h008, 12'h00C, 0);

        // Reset asserted in cycle 7 with a full queue; ready high to show reset wins.
        reset_cycle();
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 1, 0, 4, 0);
        for (int k = 2; k <= 6; k++) add(0, 0, 0, 0, 0, 1, 1, 0, 8, 0);
        add(1, 1, 0, 0, 0, 1, 1, 0, 8, 0);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 1, 0, 4, 0);

        // Pop and redirect together on a full queue: redirect wins, nothing replayed.
        reset_cycle();
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 1, 0, 4, 0);
        add(0, 1, 1, 12'h020, 0, 1, 1, 0, 8, 0);
        add(0, 1, 0, 0, 0, 1, 0, 0, 12'h020, 0);
        add(0, 1, 0, 0, 0, 1, 1, 12'h020, 12'h024, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset          = vecs[i].rst;
            out_ready      = vecs[i].rdy;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            hole           = vecs[i].hl;
            #1;
            if (vecs[i].chk) begin
                check("out_valid", i, 32'(out_valid), 32'(vecs[i].e_valid));
                check("out_pc", i, 32'(out_pc), 32'(vecs[i].e_pc));
                check("out_instr", i, out_instr,
                      vecs[i].e_valid ? rom_word(vecs[i].e_pc, vecs[i].hl) : 32'h0);
                check("rom_addr", i, 32'(rom_addr), 32'(vecs[i].e_rom));
                check("halted", i, 32'(halted), 32'(vecs[i].e_halt));
            end
        end

        // Hand-written: redirect to unaligned 0x02A near trace end, expect 0x28, 0x2C, halt.
        @(negedge clk);
        reset = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0; hole = 1'b0;
        @(negedge clk);
        reset = 1'b0; redirect_valid = 1'b1; redirect_pc = 12'h02A;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        check("redir_rom_addr", -1, 32'(rom_addr), 32'h028);
        check("redir_valid", -1, 32'(out_valid), 32'h0);
        got_halt = 1'b0;
        for (int c = 0; c < 20 && !got_halt; c++) begin
            @(negedge clk);
            #1;
            if (out_valid) seen.push_back(out_pc);
            if (halted) got_halt = 1'b1;
        end
        check("tail_halt_reached", -1, 32'(got_halt), 32'h1);
        n_seen = seen.size();
        check("tail_count", -1, 32'(n_seen), 32'd2);
        if (n_seen == 2) begin
            check("tail_pc0", -1, 32'(seen[0]), 32'h028);
            check("tail_pc1", -1, 32'(seen[1]), 32'h02C);
        end
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("halt_rom_addr_hold", -1, 32'(rom_addr), 32'd48);
        check("halt_sticky", -1, 32'(halted), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_control.md
# fetch_control

Front-end sequencer for the in-order fetch stage of the out-of-order core. Owns the program counter and drives the combinational instruction ROM address. Buffers fetched instructions in a 2-entry queue toward decode with a valid/ready handshake. Handles backend redirects (branch/flush) and halts at end of trace.

## Interface
- `ADDR_WIDTH`, 12, byte-address width of PC and ROM
- `INSTR_WIDTH`, 32, instruction width
- `TRACE_BYTES`, 48, byte length of loaded program; fetch stops at PC ≥ this value
- `clk`  in  1  clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `rom_addr`  out  ADDR_WIDTH  ROM byte address, always equals current PC
- `rom_data`  in  INSTR_WIDTH  ROM read data, combinational from `rom_addr` in the same cycle
- `redirect_valid`  in  1  backend redirect request, single-cycle pulse
- `redirect_pc`  in  ADDR_WIDTH  redirect target
- `out_valid`  out  1  queue head is valid
- `out_ready`  in  1  decode accepts head this cycle
- `out_pc`  out  ADDR_WIDTH  PC of head entry
- `out_instr`  out  INSTR_WIDTH  instruction of head entry
- `halted`  out  1  fetch state machine is in HALT

## Operation
- States: FETCH, HALT.
- Queue: 2 entries of {pc, instr}, circular, with head/tail pointers and a 2-bit count (0..2).
- `pop` = `out_valid & out_ready`.
- `end_cond` = (`rom_data` == 0) | (PC ≥ `TRACE_BYTES`). Compare in ADDR_WIDTH+1 bits so `TRACE_BYTES` = 2^ADDR_WIDTH is legal.
- `push` = FETCH & !`redirect_valid` & !`end_cond` & (count < 2 | `pop`).
- On push: enqueue {PC, `rom_data`}; PC ← PC + 4, modulo 2^ADDR_WIDTH.
- FETCH → HALT when `end_cond` & !`redirect_valid`. No enqueue that cycle and PC holds. The queue keeps draining in HALT.
- Redirect has highest priority, in any state. Queue is flushed (count ← 0, pointers ← 0, any same-cycle pop discarded). PC ← {`redirect_pc`[ADDR_WIDTH-1:2], 2'b00}. State ← FETCH.
- Full queue without a pop: PC holds and `rom_addr` holds.
- `out_pc`/`out_instr` present the head entry when count > 0, else 0. The head is stable while `out_valid` & !`out_ready`.
- `out_valid` = (count > 0). `halted` = (state == HALT).

## Timing
- Reset values: PC = 0, `rom_addr` = 0, count = 0, `out_valid` = 0, `out_pc` = 0, `out_instr` = 0, `halted` = 0, state = FETCH.
- Reset overrides redirect and handshake. Reset mid-operation discards queue contents and returns PC to 0 at the next edge.
- Fetch-to-output latency is 1 cycle. An instruction read in cycle N appears at the head in cycle N+1 if the queue was empty.
- Throughput is 1 instruction/cycle with `out_ready` held high. Push and pop in the same cycle are legal at count 2 and at count 1; count is unchanged.
- Redirect in cycle N: `out_valid` = 0 in N+1; target instruction at head in N+2.
- The HALT → FETCH transition occurs only via redirect or reset.
- `halted` asserts the cycle after `end_cond` is sampled.

## Test plan
- Reset, then `out_ready` = 1 with a 12-instruction nonzero trace (`TRACE_BYTES` = 48) → `out_pc` = 0, 4, …, 44 on consecutive cycles starting cycle 1. `halted` = 1 from cycle 13. `out_valid` = 0 from cycle 13.
- `out_ready` = 0 for cycles 0–5 → count saturates at 2 (PC 0, 4), `rom_addr` = 8 held, head pc 0 stable. Release `out_ready` → pcs 0, 4, 8 with no gap or duplicate.
- `redirect_valid` = 1 with `redirect_pc` = 0x01E in cycle 4 while the queue holds 2 entries → queue flushed, `out_valid` = 0 in cycle 5, head pc = 0x01C in cycle 6.
- Trace word at address 0x010 is 0 → pcs 0x0–0xC delivered, then HALT. Redirect to 0x004 → fetch resumes, `halted` = 0 next cycle, pc 0x4 at head.
- Assert `reset` in cycle 7 mid-stream with a full queue → cycle 8 shows `out_valid` = 0 and `rom_addr` = 0. Cycle 9 shows head pc 0.
- Full queue with simultaneous pop and redirect in the same cycle → redirect wins, popped entry not replayed, count = 0 next cycle.
